alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer that executes MIPS `multu` and `divu` by iterating the shared 32-bit ripple ALU. Each operation takes one ALU add or subtract per cycle: shift-add for multiply, restoring shift-subtract for divide. It sits beside the EX-stage ALU and, while busy, owns the ALU's `ctl`/`a`/`b`/`cin` inputs. Results land in architectural-style `hi`/`lo` registers with a one-cycle `done` pulse.

## Interface
- WIDTH, 32, operand width; must equal the ALU width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when idle
- op  in  6  funct code: 25 = multu, 27 = divu; any other value is illegal
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- busy  out  1  iteration in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; divide-by-zero or illegal op
- hi  out  WIDTH  product high word / remainder
- lo  out  WIDTH  product low word / quotient
- alu_ctl  out  6  ALU control: 32 = add, 34 = sub, 0 when idle
- alu_a  out  WIDTH  ALU operand a
- alu_b  out  WIDTH  ALU operand b
- alu_cin  out  1  ALU carry-in: 0 for add, 1 for sub
- alu_result  in  WIDTH  ALU sum
- alu_carry  in  1  ALU carry-out of bit WIDTH-1; for sub, 1 means no borrow

## Operation
- States:
  - IDLE: accepts start.
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - FIN: drives done, 1 cycle.
- Internal registers:
  - acc (WIDTH): drives hi.
  - q (WIDTH): drives lo.
  - opnd (WIDTH): latched src_b for multu, divisor for divu.
  - cnt (6 bits).
  - err_r.
- IDLE + start, op=25: acc=0, q=src_a, opnd=src_b, cnt=0 → MUL.
- MUL, each cycle:
  - ALU inputs: alu_ctl=32, alu_a=acc, alu_b=opnd, alu_cin=0.
  - s = q[0] ? {alu_carry, alu_result} : {1'b0, acc}.
  - {acc, q} ← {s, q} >> 1.
- IDLE + start, op=27, src_b≠0: acc=0, q=src_a, opnd=src_b → DIV.
- DIV, each cycle:
  - t = {acc[WIDTH-2:0], q[WIDTH-1]}.
  - ALU inputs: alu_ctl=34, alu_a=t, alu_b=opnd, alu_cin=1.
  - ge = acc[WIDTH-1] | alu_carry.
  - acc ← ge ? alu_result : t.
  - q ← {q[WIDTH-2:0], ge}.
- cnt increments each iteration. After the iteration with cnt=31 the FSM goes → FIN.
- IDLE + start, op=27, src_b=0: hi=src_a, lo=32'hFFFF_FFFF, err=1 → FIN. The ALU is not used.
- IDLE + start, illegal op: hi=0, lo=0, err=1 → FIN.
- FIN: done=1, then → IDLE. err holds its value only during done; otherwise it is 0.
- hi/lo hold their final values until the next accepted start. They are not frozen mid-operation.
- start while busy=1 or in FIN is ignored; it is not queued.
- IDLE: alu_ctl=0, alu_a=0, alu_b=0, alu_cin=0.

## Timing
- Reset (async, any state) drives all of the following to 0: state=IDLE, busy, done, err, hi, lo, alu_ctl, alu_a, alu_b, alu_cin, cnt. Reset mid-operation abandons the operation silently.
- Start accepted at edge E0:
  - busy=1 from after E0 through E32.
  - Iterations occur at edges E1..E32.
  - done=1 for the single cycle after E32. busy=0 in that cycle.
  - multu/divu latency: 33 cycles from start to done.
- divide-by-zero and illegal op: done in the cycle after E0. busy stays 0.
- Next start: earliest acceptance is the cycle after done, i.e. one bubble cycle.
- ALU path is combinational within the cycle. ALU outputs are registered-state driven, and no ALU output is registered by this block before use.

## Configuration
- MULDIV_DIV_EN:
  - Defined: divu supported as above.
  - Undefined: op=27 is treated as an illegal op (err=1, hi=lo=0), the DIV state and ge logic are not built, and alu_ctl never takes value 34.

## Test plan
- multu 7×6 → done 33 cycles after start, hi=0, lo=42, err=0; alu_ctl=32 throughout busy.
- multu 0xFFFF_FFFF×0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- divu 100/7 → lo=14, hi=2; divu 0xFFFF_FFFF/1 → lo=0xFFFF_FFFF, hi=0; divu 0x8000_0000/0xFFFF_FFFF → lo=0, hi=0x8000_0000.
- divu 5/0 → done and err in the cycle after start, hi=5, lo=0xFFFF_FFFF, busy never 1; op=32 → err=1, hi=lo=0.
- start with new operands at iteration 10 of a multu → ignored, original result produced. Then assert rst at iteration 10 → all outputs 0 immediately; the following multu 3×3 → lo=9.
- Build without MULDIV_DIV_EN: divu 100/7 → done next cycle, err=1, hi=lo=0.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multu/divu sequencer driving the shared EX-stage ALU.
// Optional divide support is built when MULDIV_DIV_EN is defined.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [5:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] CTL_ADD  = 6'd32;
    localparam logic [5:0] CTL_SUB  = 6'd34;
    localparam logic [5:0] LAST_IT  = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
`ifdef MULDIV_DIV_EN
        S_DIV,
`endif
        S_FIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opnd;
    logic [5:0]       cnt;
    logic             err_r;
    logic [WIDTH:0]   mul_s;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] div_t;
    logic             ge;

    // Restoring-divide partial remainder and "subtract fits" decision.
    always_comb begin
        div_t = {acc[WIDTH-2:0], q[WIDTH-1]};
        ge    = acc[WIDTH-1] | alu_carry;
    end
`endif

    // Shift-add step: keep the ALU sum only when the multiplier bit is set.
    always_comb begin
        mul_s = q[0] ? {alu_carry, alu_result} : {1'b0, acc};
    end

    assign hi  = acc;
    assign lo  = q;
    assign err = done & err_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state, status outputs and ALU operand steering.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_ctl   = 6'd0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MULTU) state_nxt = S_MUL;
`ifdef MULDIV_DIV_EN
                    else if (op == OP_DIVU && src_b != '0)
                        state_nxt = S_DIV;
`endif
                    else state_nxt = S_FIN;
                end
            end
            S_MUL: begin
                busy    = 1'b1;
                alu_ctl = CTL_ADD;
                alu_a   = acc;
                alu_b   = opnd;
                if (cnt == LAST_IT) state_nxt = S_FIN;
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                busy    = 1'b1;
                alu_ctl = CTL_SUB;
                alu_a   = div_t;
                alu_b   = opnd;
                alu_cin = 1'b1;
                if (cnt == LAST_IT) state_nxt = S_FIN;
            end
`endif
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: operand load on accept, one step per iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            q     <= '0;
            opnd  <= '0;
            cnt   <= 6'd0;
            err_r <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= 6'd0;
                        err_r <= 1'b0;
                        if (op == OP_MULTU) begin
                            acc  <= '0;
                            q    <= src_a;
                            opnd <= src_b;
                        end
`ifdef MULDIV_DIV_EN
                        else if (op == OP_DIVU && src_b != '0) begin
                            acc  <= '0;
                            q    <= src_a;
                            opnd <= src_b;
                        end else if (op == OP_DIVU) begin
                            acc   <= src_a;
                            q     <= '1;
                            err_r <= 1'b1;
                        end
`endif
                        else begin
                            acc   <= '0;
                            q     <= '0;
                            err_r <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_s[WIDTH:1];
                    q   <= {mul_s[0], q[WIDTH-1:1]};
                    cnt <= cnt + 6'd1;
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    acc <= ge ? alu_result : div_t;
                    q   <= {q[WIDTH-2:0], ge};
                    cnt <= cnt + 6'd1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq with a behavioural
// ALU and an arithmetic reference model (honours MULDIV_DIV_EN).
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic [32:0] alu_sum;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign alu_sum = {1'b0, alu_a}
                   + {1'b0, (alu_ctl == 6'd34) ? ~alu_b : alu_b}
                   + {32'd0, alu_cin};
    assign alu_result = alu_sum[31:0];
    assign alu_carry  = alu_sum[32];

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .hi         (hi),
        .lo         (lo),
        .alu_ctl    (alu_ctl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] eh,
                         output logic [31:0] el, output logic ee,
                         output int lat);
        logic [63:0] p;
        eh  = 32'd0;
        el  = 32'd0;
        ee  = 1'b1;
        lat = 1;
        if (o == 6'd25) begin
            p   = 64'(a) * 64'(b);
            eh  = p[63:32];
            el  = p[31:0];
            ee  = 1'b0;
            lat = 33;
        end
`ifdef MULDIV_DIV_EN
        else if (o == 6'd27 && b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else if (o == 6'd27) begin
            eh  = a % b;
            el  = a / b;
            ee  = 1'b0;
            lat = 33;
        end
`endif
    endtask

    task automatic run_op(input string tag, input logic [5:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ee;
        int          lat;
        int          cycles;
        int          nbusy;
        logic        seen;
        logic [5:0]  ectl;
        model(o, a, b, eh, el, ee, lat);
        ectl = (o == 6'd25) ? 6'd32 : 6'd34;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        cycles = 0;
        nbusy  = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (poke != 0 && cycles == poke) begin
                start = 1'b1;
                op    = 6'd25;
                src_a = $urandom;
                src_b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
            else if (busy) begin
                nbusy++;
                chk({tag, ".ctl"}, 64'(alu_ctl), 64'(ectl));
            end
        end
        start = 1'b0;
        chk({tag, ".lat"}, 64'(cycles), 64'(lat));
        chk({tag, ".nbusy"}, 64'(nbusy), 64'(lat - 1));
        chk({tag, ".busy_fin"}, 64'(busy), 64'd0);
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".lo"}, 64'(lo), 64'(el));
        chk({tag, ".err"}, 64'(err), 64'(ee));
        @(negedge clk);
        chk({tag, ".hold"}, {hi, lo}, {eh, el});
        chk({tag, ".idle"}, {61'd0, done, err, busy}, 64'd0);
    endtask

    initial begin
        int sel;
        logic [5:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        op    = 6'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.status", {61'd0, busy, done, err}, 64'd0);
        chk("rst.hilo", {hi, lo}, 64'd0);
        chk("rst.alu", {25'd0, alu_ctl, alu_cin, alu_a}, 64'd0);
        chk("rst.alub", 64'(alu_b), 64'd0);
        rst = 1'b0;

        run_op("mul7x6", 6'd25, 32'd7, 32'd6, 0);
        run_op("mulmax", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div100_7", 6'd27, 32'd100, 32'd7, 0);
        run_op("divmax_1", 6'd27, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("div8m_max", 6'd27, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div5_0", 6'd27, 32'd5, 32'd0, 0);
        run_op("illegal32", 6'd32, 32'd9, 32'd4, 0);
        run_op("mulpoke", 6'd25, 32'd7, 32'd6, 10);

        @(negedge clk);
        start = 1'b1;
        op    = 6'd25;
        src_a = 32'h1234_5678;
        src_b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.status", {61'd0, busy, done, err}, 64'd0);
        chk("arst.hilo", {hi, lo}, 64'd0);
        chk("arst.alu", {25'd0, alu_ctl, alu_cin, alu_a}, 64'd0);
        chk("arst.alub", 64'(alu_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mul3x3", 6'd25, 32'd3, 32'd3, 0);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            if (sel < 4) ro = 6'd25;
            else if (sel < 9) ro = 6'd27;
            else begin
                ro = 6'($urandom_range(0, 63));
                if (ro == 6'd25 || ro == 6'd27) ro = 6'd0;
            end
            if (sel == 6) rb = rb >> $urandom_range(8, 31);
            if (sel == 8) rb = 32'd0;
            run_op("rand", ro, ra, rb, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
